factor_search_ctrl: RTL

//  Sequencer for the mersenneFactoring trial-division core. For a given exponent p it

---
 rtl/factor_search_ctrl_if.sv | 21 ++
 rtl/factor_search_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/factor_search_ctrl_if.sv
// Handshake bundle between the factor search sequencer and one trial-division core.
// The sequencer is the master; the core is the slave.
interface factor_search_ctrl_if #(
  parameter int D_WIDTH = 32
);
  logic               core_start;
  logic [D_WIDTH-1:0] core_p;
  logic [D_WIDTH-1:0] core_d;
  logic               core_dividesBy;
  logic               core_finished;

  modport master (
    output core_start, core_p, core_d,
    input  core_dividesBy, core_finished
  );

  modport slave (
    input  core_start, core_p, core_d,
    output core_dividesBy, core_finished
  );
endinterface

// File: rtl/factor_search_ctrl.sv
// Candidate sequencer for Mersenne trial division: walks d = 2kp+1, drops d mod 8 not in {1,7},
// and hands the survivors to the core one at a time until a divisor, k_max, or d overflow.
//
// state | meaning
// IDLE  | waiting for cmd_start; results held
// INIT  | range check on p/k_max, load first candidate
// CHECK | bound/overflow test and mod-8 filter, one candidate per cycle
// ISSUE | core_start pulse with current candidate
// WAIT  | core running on current candidate
// FIN   | done pulse
// DRAIN | aborted while core busy; discard its result
module factor_search_ctrl #(
  parameter int K_WIDTH = 24,
  parameter int D_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_start,
  input  logic [D_WIDTH-1:0]    cmd_p,
  input  logic [K_WIDTH-1:0]    cmd_k_max,
  input  logic                  cmd_abort,
  factor_search_ctrl_if.master  core,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  exhausted,
  output logic [D_WIDTH-1:0]    factor,
  output logic [K_WIDTH-1:0]    k_found,
  output logic [K_WIDTH-1:0]    issued_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CHECK, S_ISSUE, S_WAIT, S_FIN, S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [D_WIDTH-1:0] p_r;
  logic [K_WIDTH-1:0] k_max_r;
  logic [D_WIDTH:0]   d_r;
  logic [K_WIDTH:0]   k_r;
  logic [D_WIDTH+1:0] d_sum;
  logic               d_over, k_over, d_pass, bad_range;

  logic core_start_c, ld_cmd, ld_first, adv, set_exh, set_found;

  // Two guard bits: d < 2^D plus 2p < 2^(D+1) can exceed D+1 bits; both fold into the overflow flag.
  assign d_sum     = {2'b00, d_r[D_WIDTH-1:0]} + {1'b0, p_r, 1'b0};
  assign d_over    = d_r[D_WIDTH];
  assign k_over    = k_r > {1'b0, k_max_r};
  assign d_pass    = (d_r[2:0] == 3'b001) || (d_r[2:0] == 3'b111);
  assign bad_range = (p_r < D_WIDTH'(2)) || (k_max_r == '0);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_start) state_nxt = S_INIT;
      S_INIT: begin
        if (cmd_abort)      state_nxt = S_IDLE;
        else if (bad_range) state_nxt = S_FIN;
        else                state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (cmd_abort)             state_nxt = S_IDLE;
        else if (k_over || d_over) state_nxt = S_FIN;
        else if (d_pass)           state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = cmd_abort ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (cmd_abort)          state_nxt = core.core_finished ? S_IDLE : S_DRAIN;
        else if (core.core_finished) state_nxt = core.core_dividesBy ? S_FIN : S_CHECK;
      end
      S_FIN:   state_nxt = S_IDLE;
      S_DRAIN: if (core.core_finished) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_FIN);
    core_start_c = (state == S_ISSUE);
    ld_cmd       = (state == S_IDLE)  && (state_nxt == S_INIT);
    ld_first     = (state == S_INIT)  && (state_nxt == S_CHECK);
    adv          = ((state == S_CHECK) || (state == S_WAIT)) && (state_nxt == S_CHECK);
    set_exh      = (state != S_WAIT)  && (state_nxt == S_FIN);
    set_found    = (state == S_WAIT)  && (state_nxt == S_FIN);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      p_r        <= '0;
      k_max_r    <= '0;
      d_r        <= '0;
      k_r        <= '0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      factor     <= '0;
      k_found    <= '0;
      issued_cnt <= '0;
    end else begin
      if (ld_cmd) begin
        p_r        <= cmd_p;
        k_max_r    <= cmd_k_max;
        d_r        <= '0;
        k_r        <= '0;
        found      <= 1'b0;
        exhausted  <= 1'b0;
        factor     <= '0;
        k_found    <= '0;
        issued_cnt <= '0;
      end
      if (ld_first) begin
        d_r <= {p_r, 1'b1};
        k_r <= (K_WIDTH+1)'(1);
      end
      if (adv) begin
        d_r <= {|d_sum[D_WIDTH+1:D_WIDTH], d_sum[D_WIDTH-1:0]};
        k_r <= k_r + (K_WIDTH+1)'(1);
      end
      if (core_start_c && (issued_cnt != '1))
        issued_cnt <= issued_cnt + K_WIDTH'(1);
      if (set_exh) exhausted <= 1'b1;
      if (set_found) begin
        found   <= 1'b1;
        factor  <= d_r[D_WIDTH-1:0];
        k_found <= k_r[K_WIDTH-1:0];
      end
    end
  end

  assign core.core_start = core_start_c;
  assign core.core_p     = p_r;
  assign core.core_d     = d_r[D_WIDTH-1:0];

endmodule
